// File: rtl/diffusion_seq_if.sv
// diffusion_seq_if: the input and output handshake bundle of the diffusion stage.
// The upstream/testbench side uses the master modport and the diffusion stage uses slave.
interface diffusion_seq_if #(
    parameter int NB = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [32*NB-1:0]  in_state;
    logic              in_inverse;
    logic              in_final;
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  out_state;

    modport master (
        output in_valid, in_state, in_inverse, in_final, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, in_inverse, in_final, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/diffusion_seq.sv
// diffusion_seq: Rijndael diffusion stage.
// Forward mode applies ShiftRows and then MixColumns. Inverse mode applies
// InvMixColumns and then InvShiftRows. The mix is spread over NB/COLS_PER_CYCLE
// clocks, and a final-round block only shifts.
module diffusion_seq #(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic           clk,
    input  logic           reset,
    diffusion_seq_if.slave bus
);
    localparam int W  = 32 * NB;
    localparam int N  = (COLS_PER_CYCLE > 0) ? NB / COLS_PER_CYCLE : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("diffusion_seq: NB must be 4, 6 or 8");
    end
    if (COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cpc
        $error("diffusion_seq: COLS_PER_CYCLE must divide NB");
    end

    typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [W-1:0]    data;
    logic [W-1:0]    mixed;
    logic [CW-1:0]   col_idx;
    logic            inverse_q;
    logic            final_q;
    logic            accept;
    logic            last_col;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Row shift amounts. Wide 256-bit blocks move rows 2 and 3 one extra place.
    function automatic int row_offset(input int r);
        return (NB == 8 && r >= 2) ? r + 1 : r;
    endfunction

    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] s, input logic inv);
        logic [W-1:0] res;
        int src;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - row_offset(r) + NB) % NB : (c + row_offset(r)) % NB;
                res[32*c + 8*r +: 8] = s[32*src + 8*r +: 8];
            end
        end
        return res;
    endfunction

    // Circulant column mix. Forward coefficients are 02 03 01 01.
    // Inverse coefficients are 0e 0b 0d 09, each built from the xtime chain.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m4 [4];
        logic [7:0]  m8 [4];
        logic [31:0] res;
        int i1, i2, i3;
        res = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[8*r +: 8];
            m2[r] = xtime(a[r]);
            m4[r] = xtime(m2[r]);
            m8[r] = xtime(m4[r]);
        end
        for (int r = 0; r < 4; r++) begin
            i1 = (r + 1) % 4;
            i2 = (r + 2) % 4;
            i3 = (r + 3) % 4;
            if (inv) begin
                res[8*r +: 8] = (m8[r] ^ m4[r] ^ m2[r]) ^ (m8[i1] ^ m2[i1] ^ a[i1])
                              ^ (m8[i2] ^ m4[i2] ^ a[i2]) ^ (m8[i3] ^ a[i3]);
            end else begin
                res[8*r +: 8] = m2[r] ^ (m2[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
            end
        end
        return res;
    endfunction

    // Replace only the columns owned by the current slice, unless this is a final round.
    function automatic logic [W-1:0] mix_slice(input logic [W-1:0] s, input int first,
                                               input logic inv, input logic fin);
        logic [W-1:0] res;
        res = s;
        if (!fin) begin
            for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                res[32*(first + j) +: 32] = mix_column(s[32*(first + j) +: 32], inv);
            end
        end
        return res;
    endfunction

    // Register image after mixing the slice selected by col_idx.
    always_comb begin
        mixed    = mix_slice(data, int'(col_idx) * COLS_PER_CYCLE, inverse_q, final_q);
        last_col = (col_idx == CW'(N - 1));
    end

    // Next-state decode and handshake outputs. Reset blocks acceptance combinationally.
    always_comb begin
        state_next    = state;
        bus.in_ready  = (state == IDLE) && !reset;
        bus.out_valid = (state == DONE);
        bus.out_state = (state == DONE) ? data : '0;
        accept        = bus.in_valid && bus.in_ready;
        case (state)
            IDLE:    if (accept)        state_next = MIX;
            MIX:     if (last_col)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Datapath. Load and pre-shift on accept, mix one slice per MIX edge,
    // and apply the inverse shift on the last inverse edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data      <= '0;
            col_idx   <= '0;
            inverse_q <= 1'b0;
            final_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data      <= bus.in_inverse ? bus.in_state : shift_rows(bus.in_state, 1'b0);
                        inverse_q <= bus.in_inverse;
                        final_q   <= bus.in_final;
                        col_idx   <= '0;
                    end
                end
                MIX: begin
                    if (last_col) begin
                        col_idx <= '0;
                        data    <= inverse_q ? shift_rows(mixed, 1'b1) : mixed;
                    end else begin
                        col_idx <= col_idx + CW'(1);
                        data    <= mixed;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_diffusion_seq.sv
// tb_diffusion_seq: directed checks of diffusion_seq for three configurations:
// NB4/CPC1, NB4/CPC2 and NB8/CPC4. Shared drivers are routed by sel.
module tb_diffusion_seq;
    localparam logic [127:0] FWD_IN  = 128'h3052411ee55db4b8f198bfe0ae1127d4;
    localparam logic [127:0] FWD_OUT = 128'h4c2606287ad3f8489a19cbe0e5816604;
    localparam logic [127:0] FIN_OUT = 128'he598271ef11141b8ae52b4e0305dbfd4;

    logic         clk = 1'b0;
    logic         rst;
    int           sel;
    logic         drv_valid, drv_inverse, drv_final, drv_ready;
    logic [255:0] drv_state;
    logic         obs_valid, obs_ready;
    logic [255:0] obs_state;
    int           n_cmp = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    diffusion_seq_if #(.NB(4)) if_a ();
    diffusion_seq_if #(.NB(4)) if_b ();
    diffusion_seq_if #(.NB(8)) if_c ();

    assign if_a.in_valid   = drv_valid && (sel == 0);
    assign if_a.in_state   = drv_state[127:0];
    assign if_a.in_inverse = drv_inverse;
    assign if_a.in_final   = drv_final;
    assign if_a.out_ready  = drv_ready;
    assign if_b.in_valid   = drv_valid && (sel == 1);
    assign if_b.in_state   = drv_state[127:0];
    assign if_b.in_inverse = drv_inverse;
    assign if_b.in_final   = drv_final;
    assign if_b.out_ready  = drv_ready;
    assign if_c.in_valid   = drv_valid && (sel == 2);
    assign if_c.in_state   = drv_state;
    assign if_c.in_inverse = drv_inverse;
    assign if_c.in_final   = drv_final;
    assign if_c.out_ready  = drv_ready;

    assign obs_valid = (sel == 0) ? if_a.out_valid : (sel == 1) ? if_b.out_valid : if_c.out_valid;
    assign obs_ready = (sel == 0) ? if_a.in_ready  : (sel == 1) ? if_b.in_ready  : if_c.in_ready;
    assign obs_state = (sel == 0) ? {128'b0, if_a.out_state} :
                       (sel == 1) ? {128'b0, if_b.out_state} : if_c.out_state;

    diffusion_seq #(.NB(4), .COLS_PER_CYCLE(1)) dut_a (.clk(clk), .reset(rst), .bus(if_a));
    diffusion_seq #(.NB(4), .COLS_PER_CYCLE(2)) dut_b (.clk(clk), .reset(rst), .bus(if_b));
    diffusion_seq #(.NB(8), .COLS_PER_CYCLE(4)) dut_c (.clk(clk), .reset(rst), .bus(if_c));

    // Present one block and hold it until the selected unit takes it.
    task automatic send_block(input int which, input logic [255:0] st, input logic inv,
                              input logic fin, output logic ok);
        ok          = 1'b0;
        sel         = which;
        drv_state   = st;
        drv_inverse = inv;
        drv_final   = fin;
        drv_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (obs_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        drv_valid = 1'b0;
    endtask

    // Count edges after acceptance until out_valid. Return -1 if out_valid never rises.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end else begin
                #0;
            end
            if (k == 1) begin
                @(posedge clk); #1;
            end
            if (obs_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        sel = 0; rst = 1'b1; drv_valid = 1'b1; drv_state = {128'b0, FWD_IN};
        drv_inverse = 1'b0; drv_final = 1'b0; drv_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready: got %b expected 0", obs_ready); end
        n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_out_valid: got %b expected 0", obs_valid); end
        n_cmp++; if (obs_state !== 256'b0) begin n_fail++; $display("[TB] FAIL rst_out_state: got %h expected 0", obs_state); end
        n_cmp++; if (if_c.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_in_ready_nb8: got %b expected 0", if_c.in_ready); end
        rst = 1'b0; drv_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", obs_ready); end
        n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_out_valid: got %b expected 0", obs_valid); end
    endtask

    task automatic test_forward();
        logic ok; int lat;
        drv_ready = 1'b1;
        send_block(0, {128'b0, FWD_IN}, 1'b0, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_accept: got %b expected 1", ok); end
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_busy_ready: got %b expected 0", obs_ready); end
        wait_out(lat);
        n_cmp++; if (lat != 4) begin n_fail++; $display("[TB] FAIL fwd_latency: got %0d expected 4", lat); end
        n_cmp++; if (obs_state[127:0] !== FWD_OUT) begin n_fail++; $display("[TB] FAIL fwd_state: got %h expected %h", obs_state[127:0], FWD_OUT); end
        @(posedge clk); #1;
        n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_handoff_valid: got %b expected 0", obs_valid); end
        n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL fwd_handoff_ready: got %b expected 1", obs_ready); end
    endtask

    task automatic test_inverse();
        logic ok; int lat;
        drv_ready = 1'b1;
        send_block(1, {128'b0, FWD_OUT}, 1'b1, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL inv_accept: got %b expected 1", ok); end
        wait_out(lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("[TB] FAIL inv_latency: got %0d expected 2", lat); end
        n_cmp++; if (obs_state[127:0] !== FWD_IN) begin n_fail++; $display("[TB] FAIL inv_state: got %h expected %h", obs_state[127:0], FWD_IN); end
        @(posedge clk); #1;
    endtask

    task automatic test_final();
        logic ok; int lat;
        drv_ready = 1'b1;
        send_block(0, {128'b0, FWD_IN}, 1'b0, 1'b1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL fin_accept: got %b expected 1", ok); end
        wait_out(lat);
        n_cmp++; if (lat != 4) begin n_fail++; $display("[TB] FAIL fin_latency: got %0d expected 4", lat); end
        n_cmp++; if (obs_state[127:0] !== FIN_OUT) begin n_fail++; $display("[TB] FAIL fin_state: got %h expected %h", obs_state[127:0], FIN_OUT); end
        @(posedge clk); #1;
    endtask

    task automatic test_nb8_final();
        logic ok; int lat;
        logic [255:0] pattern, expect_fwd, got;
        int off [4];
        off = '{0, 1, 3, 4};
        for (int b = 0; b < 32; b++) pattern[8*b +: 8] = 8'(b);
        for (int c = 0; c < 8; c++)
            for (int r = 0; r < 4; r++)
                expect_fwd[32*c + 8*r +: 8] = 8'(((c + off[r]) % 8) * 4 + r);
        drv_ready = 1'b1;
        send_block(2, pattern, 1'b0, 1'b1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL nb8_accept: got %b expected 1", ok); end
        wait_out(lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("[TB] FAIL nb8_latency: got %0d expected 2", lat); end
        n_cmp++; if (obs_state[31:0] !== 32'h130e0500) begin n_fail++; $display("[TB] FAIL nb8_col0: got %h expected 130e0500", obs_state[31:0]); end
        n_cmp++; if (obs_state !== expect_fwd) begin n_fail++; $display("[TB] FAIL nb8_state: got %h expected %h", obs_state, expect_fwd); end
        got = obs_state;
        @(posedge clk); #1;
        send_block(2, got, 1'b1, 1'b1, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL nb8_inv_accept: got %b expected 1", ok); end
        wait_out(lat);
        n_cmp++; if (lat != 2) begin n_fail++; $display("[TB] FAIL nb8_inv_latency: got %0d expected 2", lat); end
        n_cmp++; if (obs_state !== pattern) begin n_fail++; $display("[TB] FAIL nb8_inv_state: got %h expected %h", obs_state, pattern); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic ok; int lat; int leaked;
        drv_ready = 1'b0;
        send_block(0, {128'b0, FWD_IN}, 1'b0, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_accept: got %b expected 1", ok); end
        wait_out(lat);
        n_cmp++; if (lat != 4) begin n_fail++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat); end
        drv_valid = 1'b1; drv_state = {128'b0, {16{8'hff}}}; drv_inverse = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (obs_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b expected 1", i, obs_valid); end
            n_cmp++; if (obs_state[127:0] !== FWD_OUT) begin n_fail++; $display("[TB] FAIL bp_hold_state[%0d]: got %h expected %h", i, obs_state[127:0], FWD_OUT); end
            n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold_ready[%0d]: got %b expected 0", i, obs_ready); end
        end
        drv_valid = 1'b0; drv_inverse = 1'b0; drv_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_release_valid: got %b expected 0", obs_valid); end
        n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_release_ready: got %b expected 1", obs_ready); end
        leaked = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (obs_valid !== 1'b0) leaked++;
        end
        n_cmp++; if (leaked != 0) begin n_fail++; $display("[TB] FAIL bp_no_extra_block: got %0d valid cycles expected 0", leaked); end
    endtask

    task automatic test_reset_mid_mix();
        logic ok; int lat; int leaked;
        drv_ready = 1'b1;
        send_block(0, {128'b0, FWD_IN}, 1'b0, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rmix_accept: got %b expected 1", ok); end
        @(posedge clk); #1;
        rst = 1'b1; drv_valid = 1'b1;
        #1;
        n_cmp++; if (obs_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL rmix_ready_in_reset: got %b expected 0", obs_ready); end
        @(posedge clk); #1;
        n_cmp++; if (obs_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rmix_valid_after_reset: got %b expected 0", obs_valid); end
        rst = 1'b0; drv_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (obs_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rmix_ready_after: got %b expected 1", obs_ready); end
        leaked = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (obs_valid !== 1'b0) leaked++;
        end
        n_cmp++; if (leaked != 0) begin n_fail++; $display("[TB] FAIL rmix_no_partial: got %0d valid cycles expected 0", leaked); end
        send_block(0, {128'b0, FWD_IN}, 1'b0, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("[TB] FAIL rmix_fresh_accept: got %b expected 1", ok); end
        wait_out(lat);
        n_cmp++; if (lat != 4) begin n_fail++; $display("[TB] FAIL rmix_fresh_latency: got %0d expected 4", lat); end
        n_cmp++; if (obs_state[127:0] !== FWD_OUT) begin n_fail++; $display("[TB] FAIL rmix_fresh_state: got %h expected %h", obs_state[127:0], FWD_OUT); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_final();
        test_nb8_final();
        test_backpressure();
        test_reset_mid_mix();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
